// File: rtl/decode_issue_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake, branch flush and
// optional load-use bubble insertion with a saturating bubble counter (DECODE_HAZARD_CHECK_EN).
module decode_issue_reg #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [39:0]      packed_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [39:0]      packed_out,
  output logic [PC_W-1:0]  pc_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic hz;
  logic in_fire;
  logic out_fire;
  logic bubble;

`ifdef DECODE_HAZARD_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0] cad;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       ld_wb;

  // A held load that writes a non-zero register blocks any reader of that register.
  assign cad   = packed_out[30:26];
  assign rs    = packed_in[14:10];
  assign rt    = packed_in[9:5];
  assign ld_wb = packed_out[15] && packed_out[25] && (cad != 5'd0);
  assign hz    = out_valid && ld_wb && in_valid && ((rs == cad) || (rt == cad));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end
`else
  assign hz         = 1'b0;
  assign bubble_cnt = '0;
`endif

  // Reset overrides the stall terms so the decoder sees a ready register while reset is held.
  assign in_ready = !flush && (!rst_n || (!hz && (!out_valid || out_ready)));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign bubble   = !flush && hz && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      packed_out <= '0;
      pc_out     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      packed_out <= '0;
      pc_out     <= '0;
    end else if (bubble) begin
      out_valid  <= 1'b0;
      packed_out <= '0;
    end else if (in_fire) begin
      out_valid  <= 1'b1;
      packed_out <= packed_in;
      pc_out     <= pc_in;
    end else if (out_fire) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_reg.sv
// Directed self-checking bench for decode_issue_reg; expectations adapt to DECODE_HAZARD_CHECK_EN.
module tb_decode_issue_reg;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
`ifdef DECODE_HAZARD_CHECK_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [39:0]      packed_in;
  logic [PC_W-1:0]  pc_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [39:0]      packed_out;
  logic [PC_W-1:0]  pc_out;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_bub = '0;

  decode_issue_reg #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .packed_in(packed_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .packed_out(packed_out), .pc_out(pc_out), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] mk(input logic [4:0] cad, input logic we, input logic rr,
                                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    logic [39:0] w;
    w        = '0;
    w[39:36] = 4'hA;
    w[30:26] = cad;
    w[25]    = we;
    w[15]    = rr;
    w[14:10] = rs;
    w[9:5]   = rt;
    w[4:0]   = rd;
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    packed_in = '0; pc_in = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (packed_out !== 40'd0) begin errors++; $display("[TB] FAIL reset_packed: got %h expected 0", packed_out); end
    checks++; if (pc_out !== '0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", pc_out); end
    checks++; if (bubble_cnt !== '0) begin errors++; $display("[TB] FAIL reset_bubble: got %0d expected 0", bubble_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    flush = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush_ready: got %b expected 0", in_ready); end
    flush = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [39:0] w [4];
    w[0] = mk(5'd1, 1'b1, 1'b0, 5'd2, 5'd3, 5'd4);
    w[1] = mk(5'd6, 1'b1, 1'b0, 5'd1, 5'd1, 5'd9);
    w[2] = mk(5'd0, 1'b0, 1'b0, 5'd31, 5'd30, 5'd29);
    w[3] = mk(5'd17, 1'b0, 1'b1, 5'd17, 5'd6, 5'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; packed_in = w[i]; pc_in = 32'h1000 + 32'(i * 4);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || packed_out !== w[i]) begin
        errors++; $display("[TB] FAIL stream_out[%0d]: got v=%b %h expected v=1 %h", i, out_valid, packed_out, w[i]); end
      checks++; if (pc_out !== 32'h1000 + 32'(i * 4)) begin
        errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, pc_out, 32'h1000 + 32'(i * 4)); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", out_valid); end
    checks++; if (bubble_cnt !== '0) begin errors++; $display("[TB] FAIL stream_bubble: got %0d expected 0", bubble_cnt); end
  endtask

  // One load followed by a dependent reader; ends with the reader held in the register.
  task automatic load_then_dep(input logic [39:0] ld, input logic [39:0] dep, input string tag);
    in_valid = 1'b1; packed_in = ld; pc_in = 32'h2000;
    step();
    checks++; if (out_valid !== 1'b1 || packed_out !== ld) begin
      errors++; $display("[TB] FAIL %s_load: got v=%b %h expected v=1 %h", tag, out_valid, packed_out, ld); end
    packed_in = dep; pc_in = 32'h2004;
    #1;
    checks++; if (in_ready !== !HZ_EN) begin
      errors++; $display("[TB] FAIL %s_ready: got %b expected %b", tag, in_ready, !HZ_EN); end
    step();
    if (HZ_EN && exp_bub != '1) exp_bub = exp_bub + 1'b1;
    checks++; if (out_valid !== !HZ_EN || packed_out !== (HZ_EN ? 40'd0 : dep)) begin
      errors++; $display("[TB] FAIL %s_bubble_out: got v=%b %h expected v=%b %h", tag, out_valid, packed_out,
                         !HZ_EN, HZ_EN ? 40'd0 : dep); end
    checks++; if (bubble_cnt !== exp_bub) begin
      errors++; $display("[TB] FAIL %s_count: got %0d expected %0d", tag, bubble_cnt, exp_bub); end
    step();
    checks++; if (out_valid !== 1'b1 || packed_out !== dep || pc_out !== 32'h2004) begin
      errors++; $display("[TB] FAIL %s_dep: got v=%b %h pc=%h expected v=1 %h pc=2004", tag, out_valid, packed_out, pc_out, dep); end
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    load_then_dep(mk(5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3), mk(5'd7, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2), "hz_rs");
    load_then_dep(mk(5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3), mk(5'd7, 1'b1, 1'b0, 5'd1, 5'd5, 5'd2), "hz_rt");
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_no_hazard();
    logic [39:0] w [4];
    w[0] = mk(5'd0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    w[1] = mk(5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 5'd4);
    w[2] = mk(5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    w[3] = mk(5'd9, 1'b1, 1'b0, 5'd3, 5'd7, 5'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; packed_in = w[i]; pc_in = 32'h3000 + 32'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nohz_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || packed_out !== w[i]) begin
        errors++; $display("[TB] FAIL nohz_out[%0d]: got v=%b %h expected v=1 %h", i, out_valid, packed_out, w[i]); end
    end
    checks++; if (bubble_cnt !== exp_bub) begin errors++; $display("[TB] FAIL nohz_count: got %0d expected %0d", bubble_cnt, exp_bub); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [39:0] held;
    logic [39:0] ld;
    held = mk(5'd3, 1'b1, 1'b0, 5'd4, 5'd4, 5'd4);
    ld   = mk(5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1);
    out_ready = 1'b1; in_valid = 1'b1; packed_in = held; pc_in = 32'h4000;
    step();
    out_ready = 1'b0; packed_in = mk(5'd1, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1); pc_in = 32'h4004;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || packed_out !== held || pc_out !== 32'h4000) begin
        errors++; $display("[TB] FAIL stall_hold[%0d]: got v=%b %h pc=%h expected v=1 %h pc=4000", i, out_valid, packed_out, pc_out, held); end
    end
    // Hazard while the execute stage stalls, then flush on top of the hazard.
    out_ready = 1'b1; packed_in = ld; pc_in = 32'h4008;
    step();
    out_ready = 1'b0; packed_in = mk(5'd2, 1'b1, 1'b0, 5'd5, 5'd0, 5'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (packed_out !== ld || bubble_cnt !== exp_bub) begin
        errors++; $display("[TB] FAIL stall_hz[%0d]: got %h cnt=%0d expected %h cnt=%0d", i, packed_out, bubble_cnt, ld, exp_bub); end
    end
    out_ready = 1'b1; flush = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || bubble_cnt !== exp_bub) begin
      errors++; $display("[TB] FAIL flush_hz: got v=%b cnt=%0d expected v=0 cnt=%0d", out_valid, bubble_cnt, exp_bub); end
    flush = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; packed_in = mk(5'd4, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3); pc_in = 32'h5000;
    step();
    flush = 1'b1; packed_in = mk(5'd6, 1'b1, 1'b0, 5'd7, 5'd8, 5'd9); pc_in = 32'h5004;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || packed_out !== 40'd0 || pc_out !== '0) begin
      errors++; $display("[TB] FAIL flush_clear: got v=%b %h pc=%h expected v=0 0 pc=0", out_valid, packed_out, pc_out); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_not_taken: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_then_dep(mk(5'd5, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3), mk(5'd7, 1'b1, 1'b0, 5'd5, 5'd5, 5'd2), $sformatf("sat%0d", i));
    end
    checks++; if (bubble_cnt !== (HZ_EN ? 4'd15 : 4'd0)) begin
      errors++; $display("[TB] FAIL sat_final: got %0d expected %0d", bubble_cnt, HZ_EN ? 15 : 0); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; packed_in = mk(5'd3, 1'b1, 1'b0, 5'd1, 5'd1, 5'd1); pc_in = 32'h6000;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", in_ready); end
    step();
    exp_bub = '0;
    checks++; if (out_valid !== 1'b0 || packed_out !== 40'd0 || bubble_cnt !== '0) begin
      errors++; $display("[TB] FAIL mid_reset: got v=%b %h cnt=%0d expected v=0 0 cnt=0", out_valid, packed_out, bubble_cnt); end
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_after: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_no_hazard();
    test_stall();
    test_flush();
    test_saturate();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
